fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Instruction-fetch sequencer for the 16-bit lab CPU.
- Owns the program counter and issues read requests to instruction memory over a req/ack handshake.
- Pulses the instruction register's load enable when fetched data arrives, then presents the held instruction to decode over valid/ready.
- Handles branch redirects, including redirects that land while a fetch is still outstanding.

Parameters:
- DWIDTH, 16: instruction width; must match the instruction register.
- AWIDTH, 8: instruction address / PC width.
- RESET_PC, 0: PC value after reset.
- TIMEOUT, 15: maximum number of FETCH cycles without ack before error. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  level; high allows new fetches to start.
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  AWIDTH  read address; stable while mem_req is high.
- mem_ack  in  1  read data valid this cycle; completes the request.
- mem_rdata  in  DWIDTH  read data, valid when mem_ack is high.
- ir_ld  out  1  load enable to the instruction register (its en_in).
- ir_din  out  DWIDTH  data to the instruction register; equals mem_rdata (pass-through).
- dec_valid  out  1  the instruction register holds an instruction for decode.
- dec_ready  in  1  decode accepts the instruction.
- redirect  in  1  branch taken; 1-cycle pulse.
- redirect_pc  in  AWIDTH  branch target.
- pc  out  AWIDTH  address of the next instruction to fetch.
- fetch_err  out  1  sticky timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE, pc = RESET_PC, req_addr = RESET_PC, discard = 0.
  - mem_req = 0, dec_valid = 0, ir_ld = 0, fetch_err = 0.
  - Reset mid-fetch abandons the request; memory must tolerate mem_req dropping.
- Outputs:
  - mem_req = (state == FETCH); mem_addr = req_addr. Both come from registers.
  - ir_ld = (state == FETCH) & mem_ack & ~discard & ~redirect. This is combinational, so the IR captures mem_rdata on the same edge.
  - dec_valid = (state == HOLD).
- IDLE:
  - If run: req_addr <= pc, go to FETCH.
  - Otherwise stay.
- FETCH: mem_req is held high until mem_ack; the request is never withdrawn.
  - ack, no redirect, discard = 0: pc <= req_addr + 1 (wraps modulo 2^AWIDTH); go to HOLD.
  - ack with discard = 1 or redirect: data dropped, ir_ld = 0, discard <= 0.
    - The new address is redirect_pc if redirect is high this cycle, else pc.
    - If run: req_addr <= new address, stay in FETCH (the new request is issued the next cycle).
    - Otherwise go to IDLE.
  - No ack, redirect: pc <= redirect_pc, discard <= 1. mem_addr is unchanged.
- HOLD:
  - redirect has priority over dec_ready:
    - pc <= redirect_pc.
    - If run: req_addr <= redirect_pc, go to FETCH.
    - Otherwise go to IDLE.
    - The held instruction is withdrawn without handshake.
  - dec_ready: instruction consumed.
    - If run: req_addr <= pc, go to FETCH.
    - Otherwise go to IDLE.
  - Otherwise stay; the instruction register is not reloaded.
- Redirect in IDLE: pc <= redirect_pc.
- run low: never aborts a FETCH or HOLD in progress; it only prevents starting the next fetch.
- Throughput:
  - Zero-wait memory with dec_ready held high: one instruction per 2 cycles.
  - Latency from entering FETCH to dec_valid is 1 + wait cycles.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro defined:
  - A wait counter clears on entering FETCH and increments each FETCH cycle without ack.
  - When the counter reaches TIMEOUT: fetch_err <= 1 (sticky until reset), state goes to ERR.
  - ERR drives mem_req = 0 and dec_valid = 0; only reset exits it.
- Without the macro: no counter, no ERR state, fetch_err tied to 0, and FETCH waits indefinitely.

Decomposition:
- Package fetch_pkg holds:
  - state encoding localparams IDLE, FETCH, HOLD, ERR (2-bit);
  - the default widths.
- One sub-module is natural: fetch_wdog, the timeout counter with clear, count enable and expire outputs. It is instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset release, RESET_PC = 0, run = 1, ack on the first FETCH cycle, rdata = 16'h1234:
  - mem_req rises 1 cycle after run is seen;
  - ir_ld is high for one cycle with ir_din = 16'h1234;
  - dec_valid is high the next cycle; pc = 1.
- 3 wait cycles, then ack:
  - mem_addr is stable for 4 cycles;
  - exactly one ir_ld pulse; pc advances by 1.
- Redirect to 8'h40 during wait cycle 2 of a fetch to 8'h05:
  - ack data dropped, no ir_ld;
  - next request has mem_addr = 8'h40;
  - after ack, pc = 8'h41.
- HOLD with dec_ready = 0 for 5 cycles, then redirect and dec_ready together:
  - dec_valid drops;
  - next fetch address is redirect_pc, not pc.
- pc = 8'hFF, fetch completes: pc wraps to 8'h00 and the next mem_addr = 8'h00.
- FETCH_TIMEOUT_EN, TIMEOUT = 15, ack never arrives:
  - fetch_err rises after 15 cycles in FETCH;
  - mem_req goes low and stays low until rst_n is asserted.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default widths for the fetch sequencer
package fetch_pkg;

    localparam int unsigned DWIDTH_DEF  = 16;
    localparam int unsigned AWIDTH_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - fetch sequencer signal bundle: memory req/ack, IR load, decode valid/ready, redirect
interface fetch_seq_if
    import fetch_pkg::*;
#(
    parameter int unsigned AWIDTH = AWIDTH_DEF,
    parameter int unsigned DWIDTH = DWIDTH_DEF
) ();

    logic              run;
    logic              mem_req;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_ack;
    logic [DWIDTH-1:0] mem_rdata;
    logic              ir_ld;
    logic [DWIDTH-1:0] ir_din;
    logic              dec_valid;
    logic              dec_ready;
    logic              redirect;
    logic [AWIDTH-1:0] redirect_pc;
    logic [AWIDTH-1:0] pc;
    logic              fetch_err;

    modport master (
        input  run,
        input  mem_ack,
        input  mem_rdata,
        input  dec_ready,
        input  redirect,
        input  redirect_pc,
        output mem_req,
        output mem_addr,
        output ir_ld,
        output ir_din,
        output dec_valid,
        output pc,
        output fetch_err
    );

    modport slave (
        output run,
        output mem_ack,
        output mem_rdata,
        output dec_ready,
        output redirect,
        output redirect_pc,
        input  mem_req,
        input  mem_addr,
        input  ir_ld,
        input  ir_din,
        input  dec_valid,
        input  pc,
        input  fetch_err
    );

endinterface

// File: rtl/fetch_wdog.sv
// rtl/fetch_wdog.sv - wait-cycle counter for an outstanding fetch; expires on the TIMEOUT-th unacked cycle
module fetch_wdog #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the cycle whose increment would bring the count to TIMEOUT.
    assign expire_o = en_i && !clr_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction-fetch sequencer (PC, memory req/ack, IR load, decode handshake)
// Optional fetch timeout with sticky error and ERR state under FETCH_TIMEOUT_EN.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int unsigned       DWIDTH   = DWIDTH_DEF,
    parameter int unsigned       AWIDTH   = AWIDTH_DEF,
    parameter logic [AWIDTH-1:0] RESET_PC = '0
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT  = TIMEOUT_DEF
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_seq_if.master bus
);

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [AWIDTH-1:0] pc_q;
    logic [AWIDTH-1:0] pc_d;
    logic [AWIDTH-1:0] req_addr_q;
    logic [AWIDTH-1:0] req_addr_d;
    logic              discard_q;
    logic              discard_d;
    logic [AWIDTH-1:0] redir_addr;
    logic [DWIDTH-1:0] ir_data;
    logic              in_fetch;
    logic              expire;

    assign in_fetch   = (state_q == FETCH);
    assign redir_addr = bus.redirect ? bus.redirect_pc : pc_q;

`ifdef FETCH_TIMEOUT_EN
    logic err_q;
    logic wd_en;

    // Counts only unacked FETCH cycles; any other cycle restarts the count.
    assign wd_en = in_fetch && !bus.mem_ack;

    fetch_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!wd_en),
        .en_i     (wd_en),
        .expire_o (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (expire) begin
            err_q <= 1'b1;
        end
    end

    assign bus.fetch_err = err_q;
`else
    assign expire        = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        discard_d  = discard_q;
        case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                end
                if (bus.run) begin
                    req_addr_d = redir_addr;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (bus.mem_ack) begin
                    if (discard_q || bus.redirect) begin
                        // Stale or redirected data: drop it and reissue at the live address.
                        discard_d = 1'b0;
                        pc_d      = redir_addr;
                        if (bus.run) begin
                            req_addr_d = redir_addr;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        pc_d    = req_addr_q + 1'b1;
                        state_d = HOLD;
                    end
                end else begin
                    if (bus.redirect) begin
                        pc_d      = bus.redirect_pc;
                        discard_d = 1'b1;
                    end
                    if (expire) begin
                        state_d = ERR;
                    end
                end
            end
            HOLD: begin
                if (bus.redirect) begin
                    pc_d = bus.redirect_pc;
                    if (bus.run) begin
                        req_addr_d = bus.redirect_pc;
                        state_d    = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.dec_ready) begin
                    if (bus.run) begin
                        req_addr_d = pc_q;
                        state_d    = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            discard_q  <= discard_d;
        end
    end

    assign ir_data       = bus.mem_rdata;
    assign bus.ir_din    = ir_data;
    assign bus.mem_req   = in_fetch;
    assign bus.mem_addr  = req_addr_q;
    assign bus.ir_ld     = in_fetch && bus.mem_ack && !discard_q && !bus.redirect;
    assign bus.dec_valid = (state_q == HOLD);
    assign bus.pc        = pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed self-checking bench for fetch_seq
module tb_fetch_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   nld;
    int   nreq;

    fetch_seq_if #(.AWIDTH(8), .DWIDTH(16)) bus ();

    fetch_seq #(
        .DWIDTH   (16),
        .AWIDTH   (8),
        .RESET_PC (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.run = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus.dec_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        #3;
        check_eq("rst_mem_req", bus.mem_req, 0);
        check_eq("rst_dec_valid", bus.dec_valid, 0);
        check_eq("rst_ir_ld", bus.ir_ld, 0);
        check_eq("rst_pc", bus.pc, 0);
        check_eq("rst_mem_addr", bus.mem_addr, 0);
        check_eq("rst_fetch_err", bus.fetch_err, 0);
        step();
        step();

        // first fetch, zero wait
        rst_n = 1'b1;
        bus.run = 1'b1;
        look();
        check_eq("t1_req_idle", bus.mem_req, 0);
        step();
        check_eq("t1_req_rise", bus.mem_req, 1);
        check_eq("t1_addr", bus.mem_addr, 8'h00);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h1234;
        look();
        check_eq("t1_ir_ld", bus.ir_ld, 1);
        check_eq("t1_ir_din", bus.ir_din, 16'h1234);
        step();
        bus.mem_ack = 1'b0;
        look();
        check_eq("t1_dec_valid", bus.dec_valid, 1);
        check_eq("t1_pc", bus.pc, 8'h01);
        check_eq("t1_ir_ld_off", bus.ir_ld, 0);
        check_eq("t1_req_off", bus.mem_req, 0);

        // 3 wait cycles then ack
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        nld = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.mem_ack = 1'b1;
                bus.mem_rdata = 16'hABCD;
            end
            look();
            check_eq("t2_addr_stable", bus.mem_addr, 8'h01);
            nld += int'(bus.ir_ld);
            step();
        end
        bus.mem_ack = 1'b0;
        look();
        check_eq("t2_one_ir_ld", nld, 1);
        check_eq("t2_pc", bus.pc, 8'h02);
        check_eq("t2_dec_valid", bus.dec_valid, 1);

        // redirect to 0x40 during wait cycle 2 of a fetch to 0x05
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h05;
        step();
        bus.redirect = 1'b0;
        look();
        check_eq("t3_addr5", bus.mem_addr, 8'h05);
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h40;
        look();
        check_eq("t3_no_ld_redir", bus.ir_ld, 0);
        step();
        bus.redirect = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        look();
        check_eq("t3_addr_held", bus.mem_addr, 8'h05);
        check_eq("t3_pc_redir", bus.pc, 8'h40);
        check_eq("t3_drop", bus.ir_ld, 0);
        step();
        bus.mem_rdata = 16'h5555;
        look();
        check_eq("t3_req_again", bus.mem_req, 1);
        check_eq("t3_addr40", bus.mem_addr, 8'h40);
        check_eq("t3_ld40", bus.ir_ld, 1);
        step();
        bus.mem_ack = 1'b0;
        look();
        check_eq("t3_pc41", bus.pc, 8'h41);
        check_eq("t3_dec_valid", bus.dec_valid, 1);

        // HOLD stalled 5 cycles, then redirect together with dec_ready
        for (int i = 0; i < 5; i++) begin
            look();
            check_eq("t4_hold_valid", bus.dec_valid, 1);
            check_eq("t4_hold_no_ld", bus.ir_ld, 0);
            step();
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h80;
        bus.dec_ready = 1'b1;
        step();
        bus.redirect = 1'b0;
        bus.dec_ready = 1'b0;
        look();
        check_eq("t4_valid_drop", bus.dec_valid, 0);
        check_eq("t4_addr_redir", bus.mem_addr, 8'h80);
        check_eq("t4_pc", bus.pc, 8'h80);

        // PC wrap at 0xFF
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h1111;
        step();
        bus.mem_ack = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'hFF;
        step();
        bus.redirect = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'h0F0F;
        look();
        check_eq("t5_addrFF", bus.mem_addr, 8'hFF);
        check_eq("t5_ldFF", bus.ir_ld, 1);
        step();
        bus.mem_ack = 1'b0;
        look();
        check_eq("t5_pc_wrap", bus.pc, 8'h00);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        look();
        check_eq("t5_addr_wrap", bus.mem_addr, 8'h00);

        // run low completes the fetch and hold, then idles
        bus.run = 1'b0;
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        step();
        step();
        look();
        check_eq("t6_hold_runlow", bus.dec_valid, 1);
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        look();
        check_eq("t6_idle_req", bus.mem_req, 0);
        check_eq("t6_idle_valid", bus.dec_valid, 0);
        step();
        check_eq("t6_idle_stay", bus.mem_req, 0);

        // ack coinciding with redirect
        bus.run = 1'b1;
        step();
        bus.mem_ack = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 8'h22;
        look();
        check_eq("t7_addr1", bus.mem_addr, 8'h01);
        check_eq("t7_no_ld", bus.ir_ld, 0);
        step();
        bus.redirect = 1'b0;
        bus.mem_rdata = 16'h7777;
        look();
        check_eq("t7_addr22", bus.mem_addr, 8'h22);
        check_eq("t7_ld", bus.ir_ld, 1);
        step();
        bus.mem_ack = 1'b0;
        look();
        check_eq("t7_pc23", bus.pc, 8'h23);

        // reset mid-fetch
        bus.dec_ready = 1'b1;
        step();
        bus.dec_ready = 1'b0;
        look();
        check_eq("t8_req", bus.mem_req, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t8_rst_req", bus.mem_req, 0);
        check_eq("t8_rst_pc", bus.pc, 8'h00);
        check_eq("t8_rst_addr", bus.mem_addr, 8'h00);
        check_eq("t8_rst_err", bus.fetch_err, 0);

`ifdef FETCH_TIMEOUT_EN
        step();
        rst_n = 1'b1;
        bus.run = 1'b1;
        bus.mem_ack = 1'b0;
        step();
        nreq = 0;
        for (int k = 0; k < 40 && !bus.fetch_err; k++) begin
            nreq += int'(bus.mem_req);
            step();
        end
        check_eq("t9_fetch_cycles", nreq, 15);
        check_eq("t9_err", bus.fetch_err, 1);
        check_eq("t9_req_low", bus.mem_req, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("t9_err_stay_req", bus.mem_req, 0);
            check_eq("t9_err_sticky", bus.fetch_err, 1);
        end
        rst_n = 1'b0;
        #1;
        check_eq("t9_err_rst", bus.fetch_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
